// File: rtl/snd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snd_pkg : shared encodings for the multi-chip sound bus bridge   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package snd_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETUP  = 3'd1;
    localparam logic [2:0] c_ST_STROBE = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
    localparam logic [2:0] c_ST_WAIT   = 3'd4;

    // {bdir, bc1}
    localparam logic [1:0] c_BUS_IDLE = 2'b00;
    localparam logic [1:0] c_BUS_READ = 2'b01;
    localparam logic [1:0] c_BUS_DATA = 2'b10;
    localparam logic [1:0] c_BUS_ADDR = 2'b11;

    localparam logic [3:0] c_CFG_TAG       = 4'hF;
    localparam int         c_CFG_TAG_LSB   = 4;
    localparam int         c_CFG_NSTAT_BIT = 2;
    localparam int         c_CFG_SEL_LSB   = 0;

    localparam int c_ENTRY_W = 11;

    typedef struct packed {
        logic [1:0] chip;
        logic       a0;
        logic [7:0] data;
    } snd_entry_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snd_wfifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snd_wfifo : synchronous write queue, show-ahead read port        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module snd_wfifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW:0]   c_CNT_MAX = (c_AW + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == c_CNT_MAX);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop & ~o_empty;
    // A full queue still accepts a push when an entry leaves the same cycle
    assign w_do_push  = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_do_push && !w_do_pop)      r_count <= r_count + c_CNT_ONE;
            else if (!w_do_push && w_do_pop) r_count <= r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/snd_bus_nchip.sv
`default_nettype none
// +------------------------------------------------------------------+
// | snd_bus_nchip : AY-slot bus to N local YM chips, queued writes   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module snd_bus_nchip
    import snd_pkg::*;
#(
    parameter int N_CHIPS    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 2,
    parameter int WR_CYC     = 4,
    parameter int ADDR_WAIT  = 288,
    parameter int DATA_WAIT  = 1344
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bdir,
    input  logic               bc1,
    input  logic               a8,
    input  logic               a9_n,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_oe,
    output logic [7:0]         ld_out,
    output logic               ld_oe,
    input  logic [7:0]         ld_in,
    output logic [N_CHIPS-1:0] cs_n,
    output logic               rd_n,
    output logic               wr_n,
    output logic               a0,
    output logic [1:0]         sel_idx,
    output logic               stat_mode,
    output logic               overflow
);
    localparam int c_CNT_W = $clog2(max_int(max_int(SETUP_CYC, WR_CYC),
                                            max_int(ADDR_WAIT, DATA_WAIT))) + 1;
    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LD    = c_CNT_W'(WR_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_AWAIT_LD = c_CNT_W'(ADDR_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_DWAIT_LD = c_CNT_W'(DATA_WAIT - 1);

    logic r_bdir_s1, r_bdir_s2, r_bc1_s1, r_bc1_s2;
    logic r_a8_s1, r_a8_s2, r_a9n_s1, r_a9n_s2;
    logic r_wr_act, r_wr_is_addr, r_rd_prev, r_rd_strobe;
    logic [7:0] r_wr_byte;
    logic [1:0] r_sel_idx;
    logic r_stat_mode, r_overflow;
    logic [2:0] r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    snd_entry_t r_cur, w_cur_nxt, w_head, w_push_entry;
    logic [N_CHIPS-1:0] r_cs_n, w_cs_n_nxt;
    logic r_rd_n, r_wr_n, r_a0, r_ld_oe, r_dout_oe;
    logic w_rd_n_nxt, w_wr_n_nxt, w_a0_nxt, w_ld_oe_nxt;
    logic [7:0] r_ld_out, w_ld_out_nxt, r_dout;
    logic [1:0] w_code, w_cfg_sel;
    logic w_en, w_wr_now, w_rd_cyc, w_wr_end, w_is_cfg, w_cfg_ok;
    logic w_push, w_pop, w_rd_strobe, w_fifo_empty, w_fifo_full;
    logic [c_ENTRY_W-1:0] w_fifo_dout;

    assign w_en      = r_a8_s2 & ~r_a9n_s2;
    assign w_code    = w_en ? {r_bdir_s2, r_bc1_s2} : c_BUS_IDLE;
    assign w_wr_now  = (w_code == c_BUS_DATA) || (w_code == c_BUS_ADDR);
    assign w_rd_cyc  = (w_code == c_BUS_READ);
    assign w_wr_end  = r_wr_act & ~r_bdir_s2;
    assign w_is_cfg  = r_wr_is_addr && (r_wr_byte[c_CFG_TAG_LSB +: 4] == c_CFG_TAG);
    assign w_cfg_sel = r_wr_byte[c_CFG_SEL_LSB +: 2];
    assign w_cfg_ok  = (int'(w_cfg_sel) < N_CHIPS);
    assign w_push    = w_wr_end & ~w_is_cfg;
    assign w_head    = snd_entry_t'(w_fifo_dout);
    // Once a read strobe has started it keeps the bus until the read ends
    assign w_rd_strobe = w_rd_cyc && (r_state == c_ST_IDLE) && (w_fifo_empty || r_rd_strobe);

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.chip = r_sel_idx;
        w_push_entry.a0   = ~r_wr_is_addr;
        w_push_entry.data = r_wr_byte;
    end

    snd_wfifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (c_ENTRY_W)
    ) u_wfifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_dout),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_cur;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: if (!w_fifo_empty && !w_rd_strobe) begin
                w_pop       = 1'b1;
                w_cur_nxt   = w_head;
                w_state_nxt = c_ST_SETUP;
                w_cnt_nxt   = c_SETUP_LD;
            end
            c_ST_SETUP: if (r_cnt == '0) begin
                w_state_nxt = c_ST_STROBE;
                w_cnt_nxt   = c_WR_LD;
            end else w_cnt_nxt = r_cnt - 1'b1;
            c_ST_STROBE: if (r_cnt == '0) w_state_nxt = c_ST_HOLD;
                         else w_cnt_nxt = r_cnt - 1'b1;
            c_ST_HOLD: begin
                w_state_nxt = c_ST_WAIT;
                w_cnt_nxt   = r_cur.a0 ? c_DWAIT_LD : c_AWAIT_LD;
            end
            c_ST_WAIT: if (r_cnt == '0) w_state_nxt = c_ST_IDLE;
                       else w_cnt_nxt = r_cnt - 1'b1;
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they never glitch
    always_comb begin
        w_cs_n_nxt   = '1;
        w_rd_n_nxt   = 1'b1;
        w_wr_n_nxt   = 1'b1;
        w_a0_nxt     = r_a0;
        w_ld_oe_nxt  = 1'b0;
        w_ld_out_nxt = r_ld_out;
        if (w_state_nxt == c_ST_SETUP || w_state_nxt == c_ST_STROBE || w_state_nxt == c_ST_HOLD) begin
            for (int i = 0; i < N_CHIPS; i++)
                if (i == int'(w_cur_nxt.chip)) w_cs_n_nxt[i] = 1'b0;
            w_a0_nxt     = w_cur_nxt.a0;
            w_ld_out_nxt = w_cur_nxt.data;
            w_ld_oe_nxt  = 1'b1;
            w_wr_n_nxt   = (w_state_nxt != c_ST_STROBE);
        end else if (w_rd_strobe) begin
            for (int i = 0; i < N_CHIPS; i++)
                if (i == int'(r_sel_idx)) w_cs_n_nxt[i] = 1'b0;
            w_rd_n_nxt = 1'b0;
            w_a0_nxt   = ~r_stat_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_bdir_s1, r_bdir_s2, r_bc1_s1, r_bc1_s2} <= '0;
            {r_a8_s1, r_a8_s2, r_a9n_s1, r_a9n_s2}     <= '0;
            r_wr_act     <= 1'b0;
            r_wr_is_addr <= 1'b0;
            r_wr_byte    <= '0;
            r_sel_idx    <= '0;
            r_stat_mode  <= 1'b0;
            r_overflow   <= 1'b0;
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_cur        <= '0;
            r_cs_n       <= '1;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_a0         <= 1'b0;
            r_ld_oe      <= 1'b0;
            r_ld_out     <= '0;
            r_dout       <= 8'hFF;
            r_dout_oe    <= 1'b0;
            r_rd_prev    <= 1'b0;
            r_rd_strobe  <= 1'b0;
        end else begin
            {r_bdir_s1, r_bdir_s2} <= {bdir, r_bdir_s1};
            {r_bc1_s1, r_bc1_s2}   <= {bc1, r_bc1_s1};
            {r_a8_s1, r_a8_s2}     <= {a8, r_a8_s1};
            {r_a9n_s1, r_a9n_s2}   <= {a9_n, r_a9n_s1};
            r_wr_act <= w_wr_now;
            if (w_wr_now) begin
                r_wr_byte    <= din;
                r_wr_is_addr <= r_bc1_s2;
            end
            if (w_wr_end && w_is_cfg && w_cfg_ok) begin
                r_sel_idx   <= w_cfg_sel;
                r_stat_mode <= ~r_wr_byte[c_CFG_NSTAT_BIT];
            end
            if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cur       <= w_cur_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_rd_n      <= w_rd_n_nxt;
            r_wr_n      <= w_wr_n_nxt;
            r_a0        <= w_a0_nxt;
            r_ld_oe     <= w_ld_oe_nxt;
            r_ld_out    <= w_ld_out_nxt;
            r_rd_prev   <= w_rd_cyc;
            r_rd_strobe <= w_rd_strobe;
            r_dout_oe   <= w_rd_cyc & r_rd_prev;
            if (r_rd_strobe) r_dout <= ld_in;
            else if (w_rd_cyc && !w_rd_strobe && r_stat_mode) r_dout <= 8'h80;
        end
    end

    assign cs_n      = r_cs_n;
    assign rd_n      = r_rd_n;
    assign wr_n      = r_wr_n;
    assign a0        = r_a0;
    assign ld_oe     = r_ld_oe;
    assign ld_out    = r_ld_out;
    assign dout      = r_dout;
    assign dout_oe   = r_dout_oe;
    assign sel_idx   = r_sel_idx;
    assign stat_mode = r_stat_mode;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_snd_bus_nchip.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_snd_bus_nchip : directed bench for snd_bus_nchip              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_snd_bus_nchip;
    localparam int N_CHIPS    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int SETUP_CYC  = 2;
    localparam int WR_CYC     = 4;
    localparam int ADDR_WAIT  = 8;
    localparam int DATA_WAIT  = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic bdir = 1'b0, bc1 = 1'b0, a8 = 1'b0, a9_n = 1'b1;
    logic [7:0] din = 8'h00, ld_in = 8'h00;
    logic [7:0] dout, ld_out;
    logic dout_oe, ld_oe, rd_n, wr_n, a0, stat_mode, overflow;
    logic [N_CHIPS-1:0] cs_n;
    logic [1:0] sel_idx;

    always #5 clk = ~clk;

    snd_bus_nchip #(
        .N_CHIPS (N_CHIPS), .FIFO_DEPTH (FIFO_DEPTH), .SETUP_CYC (SETUP_CYC),
        .WR_CYC (WR_CYC), .ADDR_WAIT (ADDR_WAIT), .DATA_WAIT (DATA_WAIT)
    ) dut (
        .clk (clk), .rst_n (rst_n), .bdir (bdir), .bc1 (bc1), .a8 (a8), .a9_n (a9_n),
        .din (din), .dout (dout), .dout_oe (dout_oe), .ld_out (ld_out), .ld_oe (ld_oe),
        .ld_in (ld_in), .cs_n (cs_n), .rd_n (rd_n), .wr_n (wr_n), .a0 (a0),
        .sel_idx (sel_idx), .stat_mode (stat_mode), .overflow (overflow)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: logs write transfers as {chip, a0, byte} and their timing
    logic [10:0] xfers[$];
    int cs_lens[$], wr_lens[$], gaps[$];
    int cs_run = 0, wr_run = 0, gap_run = 0, rd_low = 0, both_low = 0, multi_cs = 0;

    always @(negedge clk) begin
        int nlow;
        logic [1:0] chip;
        nlow = 0;
        chip = 2'd0;
        if (!rst_n) begin
            cs_run = 0;
            wr_run = 0;
        end else begin
            for (int i = 0; i < N_CHIPS; i++)
                if (!cs_n[i]) begin nlow++; chip = 2'(i); end
            if (nlow > 1) multi_cs++;
            if (!rd_n && !wr_n) both_low++;
            if (!rd_n) rd_low++;
            if (nlow > 0 && ld_oe) begin
                if (cs_run == 0) gaps.push_back(gap_run);
                gap_run = 0;
                cs_run++;
            end else begin
                if (cs_run > 0) cs_lens.push_back(cs_run);
                cs_run = 0;
                gap_run++;
            end
            if (!wr_n) begin
                if (wr_run == 0) xfers.push_back({chip, a0, ld_out});
                wr_run++;
            end else if (wr_run > 0) begin
                wr_lens.push_back(wr_run);
                wr_run = 0;
            end
        end
    end

    task automatic bus_wr(input logic is_addr, input logic [7:0] d);
        @(posedge clk); #1;
        din = d; bc1 = is_addr; bdir = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bdir = 1'b0; bc1 = 1'b0;
        @(posedge clk);
    endtask

    task automatic bus_rd(output logic [7:0] o_d, output logic o_oe, output logic o_rdn,
                          output logic o_a0, output logic [N_CHIPS-1:0] o_cs);
        @(posedge clk); #1;
        bc1 = 1'b1; bdir = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        o_d = dout; o_oe = dout_oe; o_rdn = rd_n; o_a0 = a0; o_cs = cs_n;
        @(posedge clk); #1;
        bc1 = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int xb, cb, wb, gb, rb, k;
        logic [7:0] r_d;
        logic r_oe, r_rdn, r_a0;
        logic [N_CHIPS-1:0] r_cs;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_strobes", {rd_n, wr_n, a0, ld_oe, dout_oe}, 5'b11000);
        check("rst_dout", dout, 8'hFF);
        check("rst_ld_out", ld_out, 8'h00);
        check("rst_cfg", {sel_idx, stat_mode, overflow}, 4'b0000);
        rst_n = 1'b1;
        a8 = 1'b1;

        // chip enable not asserted (a9_n high): cycle ignored
        xb = xfers.size();
        bus_wr(1'b0, 8'h99);
        settle(30);
        check("disabled_wr", xfers.size() - xb, 0);
        a9_n = 1'b0;

        // address 0x27 then data 0x15 on chip 0
        xb = xfers.size(); cb = cs_lens.size(); wb = wr_lens.size(); gb = gaps.size();
        bus_wr(1'b1, 8'h27);
        bus_wr(1'b0, 8'h15);
        settle(80);
        check("t1_count", xfers.size() - xb, 2);
        check("t1_addr", xfers[xb], 11'h027);
        check("t1_data", xfers[xb+1], 11'h115);
        check("t1_cs_len0", cs_lens[cb], 7);
        check("t1_cs_len1", cs_lens[cb+1], 7);
        check("t1_wr_len0", wr_lens[wb], 4);
        check("t1_wr_len1", wr_lens[wb+1], 4);
        check("t1_gap", gaps[gb+1], ADDR_WAIT + 1);

        // chip select via config; queued entries keep the chip they were pushed with
        bus_wr(1'b1, 8'hFD);
        settle(4);
        check("cfg_fd", {sel_idx, stat_mode}, 3'b010);
        xb = xfers.size();
        bus_wr(1'b0, 8'h55);
        bus_wr(1'b0, 8'h66);
        bus_wr(1'b1, 8'hFC);
        bus_wr(1'b0, 8'hAA);
        bus_wr(1'b1, 8'hF3);
        bus_wr(1'b1, 8'hFE);
        settle(4);
        check("cfg_ignored", {sel_idx, stat_mode}, 3'b000);
        settle(100);
        check("t2_count", xfers.size() - xb, 3);
        check("t2_chip1_a", xfers[xb], 11'h355);
        check("t2_chip1_b", xfers[xb+1], 11'h366);
        check("t2_chip0", xfers[xb+2], 11'h1AA);

        // overflow: one in flight, four queued, fifth dropped
        check("ovf_before", overflow, 1'b0);
        xb = xfers.size();
        bus_wr(1'b0, 8'hA0);
        for (int i = 1; i <= 5; i++) bus_wr(1'b0, 8'hB0 + 8'(i));
        settle(160);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_count", xfers.size() - xb, 5);
        check("ovf_first", xfers[xb], 11'h1A0);
        for (int i = 1; i <= 4; i++) check("ovf_entry", xfers[xb+i], 11'h1B0 + 11'(i));

        // status reads: busy returns 0x80 without strobe, idle reads the chip
        bus_wr(1'b1, 8'hF8);
        settle(4);
        check("cfg_f8", {sel_idx, stat_mode}, 3'b001);
        ld_in = 8'h03;
        rb = rd_low;
        bus_wr(1'b0, 8'h44);
        bus_rd(r_d, r_oe, r_rdn, r_a0, r_cs);
        check("busy_dout", r_d, 8'h80);
        check("busy_oe", r_oe, 1'b1);
        check("busy_no_rd", rd_low - rb, 0);
        settle(60);
        bus_rd(r_d, r_oe, r_rdn, r_a0, r_cs);
        check("stat_rd_n", r_rdn, 1'b0);
        check("stat_a0", r_a0, 1'b0);
        check("stat_cs_n", r_cs, 2'b10);
        check("stat_dout", r_d, 8'h03);
        check("stat_oe", r_oe, 1'b1);
        settle(4);
        check("rd_release", {dout_oe, rd_n}, 2'b01);
        bus_wr(1'b1, 8'hFC);
        ld_in = 8'h5A;
        settle(4);
        bus_rd(r_d, r_oe, r_rdn, r_a0, r_cs);
        check("data_rd_a0", r_a0, 1'b1);
        check("data_rd_dout", r_d, 8'h5A);

        // reset in the middle of a write strobe
        settle(4);
        bus_wr(1'b0, 8'h77);
        bus_wr(1'b0, 8'h78);
        k = 0;
        while (wr_n && k < 40) begin @(negedge clk); k++; end
        check("strobe_seen", k < 40, 1'b1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_n", wr_n, 1'b1);
        check("rst_mid_cs_n", cs_n, 2'b11);
        check("rst_mid_ld_oe", ld_oe, 1'b0);
        xb = xfers.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle(80);
        check("rst_no_strobes", xfers.size() - xb, 0);
        check("rst_cfg_clear", {sel_idx, stat_mode, overflow}, 4'b0000);

        check("no_rd_wr_overlap", both_low, 0);
        check("single_cs", multi_cs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
